dmem_arbiter: RTL and testbench
===============================

DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 Parameter: LOCK_MAX, 8, max consecutive grant cycles one requester may hold via lock while the other requests (range 1..15).
REQ-002 clk  input  1  system clock; all state updates on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 a_req / a_wr / a_lock  input  1 each  core port: request, write (1) or read (0), hold ownership next cycle.
REQ-005 a_addr  input  6  core word address; a_wdata  input  32  core write data.
REQ-006 a_gnt  output  1  core access performed this cycle; a_rdata  output  32  read data; a_rvalid  output  1  a_rdata valid.
REQ-007 b_req / b_wr / b_lock / b_addr[6] / b_wdata[32] inputs; b_gnt / b_rdata[32] / b_rvalid outputs: loader/debug port, same meaning as port A.
REQ-008 daddr  output  6  to dmem addr; dwr  output  1  to dmem wr; ddin  output  32  to dmem din; ddout  input  32  from dmem dout (combinational read).

Function
REQ-009 Registered owner FSM, states IDLE, OWN_A, OWN_B; plus 1-bit last-served pointer and 4-bit lock counter.
REQ-010 x_gnt = (state==OWN_x) & x_req; at most one gnt high per cycle.
REQ-011 While x_gnt: daddr=x_addr, ddin=x_wdata, dwr=x_wr; otherwise daddr=0, ddin=0, dwr=0.
REQ-012 Write commits at the rising edge closing the x_gnt cycle.
REQ-013 Read: x_rdata=ddout and x_rvalid=1 in the same cycle as x_gnt with x_wr=0; else x_rdata=0, x_rvalid=0.
REQ-014 Latency: req first sampled high at edge n gives gnt in cycle after edge n at earliest (1-cycle arbitration).
REQ-015 Requester holds addr/wr/wdata stable from req assertion until gnt; one access per gnt cycle.
REQ-016 Next-owner rule at each edge, evaluated in order: (1) owner x has x_gnt & x_lock and lock counter < LOCK_MAX-1 -> stay OWN_x, counter+1; (2) both req -> grant the port not last served; (3) single req -> grant it; (4) none -> IDLE.
REQ-017 Lock counter clears whenever ownership changes or owner does not assert lock; when counter reaches LOCK_MAX-1, lock ignored and rule (2)/(3) applies (other port wins if requesting, else owner regranted).
REQ-018 Last-served pointer updates to x on every x_gnt cycle.
REQ-019 Owner deasserting req while in OWN_x: no access, gnt low, FSM re-evaluates by REQ-016 at next edge.
REQ-020 Lone requester with continuous req is granted every cycle (back-to-back, no idle bubble).

Reset
REQ-021 rst high at an edge: state=IDLE, pointer=B (so A wins first tie), lock counter=0, stats counters=0.
REQ-022 During and in cycle after reset: all gnt, rvalid, dwr = 0; rdata, daddr, ddin = 0.
REQ-023 Reset mid-access aborts the grant; a write whose gnt cycle is cut by rst at the same edge is not guaranteed; bench avoids it.

Configuration
REQ-024 Macro DMEM_ARB_STATS_EN defined: adds outputs a_count[16], b_count[16], incremented on each x_gnt cycle, saturating at 16'hFFFF, cleared by rst.
REQ-025 Macro undefined: count ports and counters absent; all other behaviour identical.

Verification
REQ-026 Reset 2 cycles, then a_req=1 a_wr=1 a_addr=5 a_wdata=32'hDEADBEEF -> a_gnt next cycle, dwr=1 daddr=5; following a read of addr 5 returns a_rdata=32'hDEADBEEF with a_rvalid=1.
REQ-027 a_req and b_req rise same cycle, both held 4 accesses -> gnt sequence A,B,A,B,... no cycle with both gnt.
REQ-028 b_lock=1 with b_req held, a_req held, LOCK_MAX=8 -> b_gnt 8 consecutive cycles, then a_gnt exactly one cycle later.
REQ-029 a_req alone held 10 cycles -> a_gnt 10 consecutive cycles after 1-cycle latency; b_* outputs stay 0.
REQ-030 rst asserted while OWN_B -> next cycle all gnt=0, dwr=0; first tie after reset goes to A; with DMEM_ARB_STATS_EN, counts read 0 after reset and 3 after three a_gnt cycles.

Source files
------------

// File: rtl/dmem_arbiter_if.sv
// dmem_arbiter_if: core port A, loader port B and dmem-side bus bundle; DMEM_ARB_STATS_EN adds grant counters
interface dmem_arbiter_if;
    logic        a_req, a_wr, a_lock, a_gnt, a_rvalid;
    logic [5:0]  a_addr;
    logic [31:0] a_wdata, a_rdata;
    logic        b_req, b_wr, b_lock, b_gnt, b_rvalid;
    logic [5:0]  b_addr;
    logic [31:0] b_wdata, b_rdata;
    logic [5:0]  daddr;
    logic        dwr;
    logic [31:0] ddin, ddout;
`ifdef DMEM_ARB_STATS_EN
    logic [15:0] a_count, b_count;
`endif
    modport slave (
`ifdef DMEM_ARB_STATS_EN
        output a_count, b_count,
`endif
        input  a_req, a_wr, a_lock, a_addr, a_wdata,
        input  b_req, b_wr, b_lock, b_addr, b_wdata,
        input  ddout,
        output a_gnt, a_rdata, a_rvalid,
        output b_gnt, b_rdata, b_rvalid,
        output daddr, dwr, ddin
    );
    modport master (
`ifdef DMEM_ARB_STATS_EN
        input  a_count, b_count,
`endif
        output a_req, a_wr, a_lock, a_addr, a_wdata,
        output b_req, b_wr, b_lock, b_addr, b_wdata,
        output ddout,
        input  a_gnt, a_rdata, a_rvalid,
        input  b_gnt, b_rdata, b_rvalid,
        input  daddr, dwr, ddin
    );
endinterface

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port dmem arbiter with bounded lock and alternating tie break; DMEM_ARB_STATS_EN adds saturating grant counters
module dmem_arbiter #(
    parameter int LOCK_MAX = 8
) (
    input logic           clk,
    input logic           rst,
    dmem_arbiter_if.slave bus
);
    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;
    state_t     state;
    logic       last_b;
    logic [3:0] lock_cnt;
    logic       a_gnt, b_gnt, last_b_eff, hold;
    // grants follow the registered owner; rst masks everything in the reset cycle
    always_comb begin
        a_gnt      = !rst && state == OWN_A && bus.a_req;
        b_gnt      = !rst && state == OWN_B && bus.b_req;
        last_b_eff = b_gnt || (!a_gnt && last_b);
        hold       = ((a_gnt && bus.a_lock) || (b_gnt && bus.b_lock)) && lock_cnt < 4'(LOCK_MAX - 1);
    end
    assign bus.a_gnt    = a_gnt;
    assign bus.b_gnt    = b_gnt;
    assign bus.daddr    = a_gnt ? bus.a_addr : b_gnt ? bus.b_addr : '0;
    assign bus.ddin     = a_gnt ? bus.a_wdata : b_gnt ? bus.b_wdata : '0;
    assign bus.dwr      = a_gnt ? bus.a_wr : b_gnt && bus.b_wr;
    assign bus.a_rvalid = a_gnt && !bus.a_wr;
    assign bus.b_rvalid = b_gnt && !bus.b_wr;
    assign bus.a_rdata  = bus.a_rvalid ? bus.ddout : '0;
    assign bus.b_rdata  = bus.b_rvalid ? bus.ddout : '0;
    // owner FSM: bounded lock first, then alternate on ties, else single requester, else idle
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            last_b   <= 1'b1;
            lock_cnt <= '0;
        end else begin
            last_b   <= last_b_eff;
            lock_cnt <= hold ? lock_cnt + 4'd1 : '0;
            state    <= hold ? state
                      : (bus.a_req && bus.b_req) ? (last_b_eff ? OWN_A : OWN_B)
                      : bus.a_req ? OWN_A
                      : bus.b_req ? OWN_B
                      : IDLE;
        end
    end
`ifdef DMEM_ARB_STATS_EN
    // per-port grant counters, saturating at all-ones
    always_ff @(posedge clk) begin
        if (rst) begin
            bus.a_count <= '0;
            bus.b_count <= '0;
        end else begin
            if (a_gnt && bus.a_count != 16'hFFFF) bus.a_count <= bus.a_count + 16'd1;
            if (b_gnt && bus.b_count != 16'hFFFF) bus.b_count <= bus.b_count + 16'd1;
        end
    end
`endif
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: scoreboard bench with a cycle-level reference model and a behavioural dmem
module tb_dmem_arbiter;
    localparam int LM = 8;
    logic clk = 1'b1;
    logic rst;
    dmem_arbiter_if bus ();
    dmem_arbiter #(.LOCK_MAX(LM)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;

    typedef struct packed {
        logic        ag, bg, dw, av, bv;
        logic [5:0]  da;
        logic [31:0] dd, ar, br;
        logic [15:0] ac, bc;
    } exp_t;
    exp_t sb[$];
    exp_t m;
    int checks = 0;
    int errors = 0;

    logic [31:0] mem [64];
    logic [31:0] ref_mem [64];
    assign bus.ddout = mem[bus.daddr];

    // dmem: combinational read, write on rising edge
    initial begin
        for (int i = 0; i < 64; i++) mem[i] = i * 32'h9E3779B9;
        forever begin
            @(posedge clk);
            if (bus.dwr) mem[bus.daddr] <= bus.ddin;
        end
    end

    // reference model: current owner (0 none, 1 A, 2 B), last served port, lock streak, grant tallies
    int m_owner, m_last, m_streak, ac, bc;
    logic last_ga, last_gb;

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %h expected %h at %0t", nm, got, want, $time);
        end
    endtask

    task automatic set_a(input logic r, input logic w, input logic l, input logic [5:0] ad, input logic [31:0] d);
        bus.a_req = r; bus.a_wr = w; bus.a_lock = l; bus.a_addr = ad; bus.a_wdata = d;
    endtask

    task automatic set_b(input logic r, input logic w, input logic l, input logic [5:0] ad, input logic [31:0] d);
        bus.b_req = r; bus.b_wr = w; bus.b_lock = l; bus.b_addr = ad; bus.b_wdata = d;
    endtask

    task automatic idle();
        set_a(0, 0, 0, 0, 0);
        set_b(0, 0, 0, 0, 0);
    endtask

    // predict this cycle's outputs from current inputs, queue them, advance the model across the edge
    task automatic step();
        exp_t e;
        logic ga, gb;
        int now_last;
        ga = !rst && m_owner == 1 && bus.a_req;
        gb = !rst && m_owner == 2 && bus.b_req;
        e = '0;
        e.ag = ga;
        e.bg = gb;
        e.ac = 16'(ac);
        e.bc = 16'(bc);
        if (ga) begin
            e.da = bus.a_addr; e.dw = bus.a_wr; e.dd = bus.a_wdata;
            if (!bus.a_wr) begin e.av = 1; e.ar = ref_mem[bus.a_addr]; end
            else ref_mem[bus.a_addr] = bus.a_wdata;
        end
        if (gb) begin
            e.da = bus.b_addr; e.dw = bus.b_wr; e.dd = bus.b_wdata;
            if (!bus.b_wr) begin e.bv = 1; e.br = ref_mem[bus.b_addr]; end
            else ref_mem[bus.b_addr] = bus.b_wdata;
        end
        sb.push_back(e);
        if (rst) begin
            m_owner = 0; m_last = 2; m_streak = 0; ac = 0; bc = 0;
        end else begin
            now_last = ga ? 1 : gb ? 2 : m_last;
            if (ga && ac < 65535) ac++;
            if (gb && bc < 65535) bc++;
            if (((ga && bus.a_lock) || (gb && bus.b_lock)) && m_streak < LM - 1) m_streak++;
            else begin
                m_streak = 0;
                m_owner = (bus.a_req && bus.b_req) ? 3 - now_last : bus.a_req ? 1 : bus.b_req ? 2 : 0;
            end
            m_last = now_last;
        end
        last_ga = ga;
        last_gb = gb;
        @(posedge clk);
        #1;
    endtask

    // monitor: every mid-cycle sample is compared against the oldest queued prediction
    always @(negedge clk) begin
        if (sb.size() > 0) begin
            m = sb.pop_front();
            chk("a_gnt", 32'(bus.a_gnt), 32'(m.ag));
            chk("b_gnt", 32'(bus.b_gnt), 32'(m.bg));
            chk("daddr", 32'(bus.daddr), 32'(m.da));
            chk("dwr", 32'(bus.dwr), 32'(m.dw));
            chk("ddin", bus.ddin, m.dd);
            chk("a_rvalid", 32'(bus.a_rvalid), 32'(m.av));
            chk("a_rdata", bus.a_rdata, m.ar);
            chk("b_rvalid", 32'(bus.b_rvalid), 32'(m.bv));
            chk("b_rdata", bus.b_rdata, m.br);
`ifdef DMEM_ARB_STATS_EN
            chk("a_count", 32'(bus.a_count), 32'(m.ac));
            chk("b_count", 32'(bus.b_count), 32'(m.bc));
`endif
        end
    end

    initial begin
        for (int i = 0; i < 64; i++) ref_mem[i] = i * 32'h9E3779B9;
        m_owner = 0; m_last = 2; m_streak = 0; ac = 0; bc = 0;
        last_ga = 0; last_gb = 0;
        rst = 1; idle();
        step(); step();
        rst = 0;
        // write then read back through port A
        set_a(1, 1, 0, 5, 32'hDEADBEEF);
        #3 chk("wr_latency", 32'(bus.a_gnt), 0);
        step();
        #3 chk("wr_gnt", 32'(bus.a_gnt), 1);
        chk("wr_dwr", 32'(bus.dwr), 1);
        chk("wr_daddr", 32'(bus.daddr), 5);
        step();
        set_a(1, 0, 0, 5, 0);
        #3 chk("rd_rvalid", 32'(bus.a_rvalid), 1);
        chk("rd_rdata", bus.a_rdata, 32'hDEADBEEF);
        step();
        idle(); step();
        // simultaneous requests alternate starting with A
        rst = 1; step(); rst = 0;
        set_a(1, 0, 0, 10, 0); set_b(1, 0, 0, 20, 0);
        step();
        for (int i = 0; i < 8; i++) begin
            #3 chk("tie_a", 32'(bus.a_gnt), 32'(i % 2 == 0));
            chk("tie_b", 32'(bus.b_gnt), 32'(i % 2 == 1));
            step();
        end
        idle(); step();
        // B locks for LOCK_MAX cycles, then A takes over
        rst = 1; step(); rst = 0;
        set_b(1, 0, 1, 7, 0);
        step();
        set_a(1, 0, 0, 3, 0);
        for (int i = 0; i < LM; i++) begin
            #3 chk("lock_b", 32'(bus.b_gnt), 1);
            chk("lock_a", 32'(bus.a_gnt), 0);
            step();
        end
        #3 chk("lock_release", 32'(bus.a_gnt), 1);
        step();
        idle(); step();
        // lone requester granted back-to-back
        rst = 1; step(); rst = 0;
        set_a(1, 0, 0, 9, 0);
        step();
        for (int i = 0; i < 10; i++) begin
            #3 chk("solo_a", 32'(bus.a_gnt), 1);
            chk("solo_b", 32'(bus.b_gnt | bus.b_rvalid | (bus.b_rdata != 0)), 0);
            step();
        end
        idle(); step();
        // reset while B owns, then first tie goes to A
        rst = 1; step(); rst = 0;
        set_b(1, 0, 0, 1, 0);
        step();
        #3 chk("own_b", 32'(bus.b_gnt), 1);
        step();
        rst = 1;
        #3 chk("rst_gnt", 32'(bus.b_gnt), 0);
        step();
        rst = 0;
        set_a(1, 0, 0, 2, 0);
        #3 chk("post_rst_gnt", 32'(bus.a_gnt | bus.b_gnt), 0);
        chk("post_rst_dwr", 32'(bus.dwr), 0);
`ifdef DMEM_ARB_STATS_EN
        chk("cnt_zero", 32'(bus.a_count) + 32'(bus.b_count), 0);
`endif
        step();
        #3 chk("first_tie_a", 32'(bus.a_gnt), 1);
        chk("first_tie_b", 32'(bus.b_gnt), 0);
        step();
        idle(); step();
`ifdef DMEM_ARB_STATS_EN
        rst = 1; step(); rst = 0;
        set_a(1, 0, 0, 4, 0);
        step(); step(); step(); step();
        idle();
        #3 chk("cnt_three", 32'(bus.a_count), 3);
        step();
`endif
        // randomized traffic; a requester keeps its transaction stable until granted
        rst = 1; step(); rst = 0;
        for (int n = 0; n < 3000; n++) begin
            if (!(bus.a_req && !last_ga))
                set_a(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      6'($urandom_range(0, 63)), $urandom);
            if (!(bus.b_req && !last_gb))
                set_b(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      6'($urandom_range(0, 63)), $urandom);
            rst = ($urandom_range(0, 299) == 0);
            step();
        end
        rst = 0; idle();
        step(); step();
        chk("sb_drain", 32'(sb.size()), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
